// File: rtl/exec_muldiv_pkg.sv
// ============================================================================
// Module : exec_muldiv_pkg
// Brief  : Funct codes, FSM encodings and decode helpers for exec_muldiv.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exec_muldiv_pkg;

   localparam logic [5:0] c_funct_mfhi  = 6'b010000;
   localparam logic [5:0] c_funct_mthi  = 6'b010001;
   localparam logic [5:0] c_funct_mflo  = 6'b010010;
   localparam logic [5:0] c_funct_mtlo  = 6'b010011;
   localparam logic [5:0] c_funct_mult  = 6'b011000;
   localparam logic [5:0] c_funct_multu = 6'b011001;
   localparam logic [5:0] c_funct_div   = 6'b011010;
   localparam logic [5:0] c_funct_divu  = 6'b011011;

   localparam logic [1:0] c_state_idle = 2'd0;
   localparam logic [1:0] c_state_calc = 2'd1;
   localparam logic [1:0] c_state_fix  = 2'd2;

   function automatic logic is_muldiv(input logic [5:0] f);
      return f inside {c_funct_mult, c_funct_multu, c_funct_div, c_funct_divu};
   endfunction

   function automatic logic is_hilo(input logic [5:0] f);
      return is_muldiv(f) ||
             (f inside {c_funct_mfhi, c_funct_mthi, c_funct_mflo, c_funct_mtlo});
   endfunction

endpackage

`default_nettype wire

// File: rtl/exec_muldiv_iter_core.sv
// ============================================================================
// Module : exec_muldiv_iter_core
// Brief  : Radix-2 shift-add multiply / restoring divide on unsigned operands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_muldiv_iter_core #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             step_done,
   output logic [WIDTH-1:0] raw_hi,
   output logic [WIDTH-1:0] raw_lo
);

   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_div;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_shifted;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;

   // Divide keeps the partial remainder in r_hi and shifts quotient bits into r_lo;
   // the true difference is below the divisor, so WIDTH-bit wraparound is exact.
   always_comb begin
      w_add     = {1'b0, r_hi} + {1'b0, r_b};
      w_shifted = {r_hi, r_lo[WIDTH-1]};
      w_ge      = (w_shifted >= {1'b0, r_b});
      w_diff    = w_shifted[WIDTH-1:0] - r_b;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
      end else if (load) begin
         r_b      <= op_b;
         r_hi     <= '0;
         r_lo     <= op_a;
         r_cnt    <= CNT_W'(WIDTH);
         r_is_div <= is_div;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
         if (r_is_div) begin
            if (w_ge) begin
               r_hi <= w_diff;
               r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
               r_hi <= w_shifted[WIDTH-1:0];
               r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
         end else if (r_lo[0]) begin
            {r_hi, r_lo} <= {w_add, r_lo[WIDTH-1:1]};
         end else begin
            {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
         end
      end
   end

   assign step_done = (r_cnt == CNT_W'(1));
   assign raw_hi    = r_hi;
   assign raw_lo    = r_lo;

endmodule

`default_nettype wire

// File: rtl/exec_muldiv.sv
// ============================================================================
// Module : exec_muldiv
// Brief  : Multi-cycle HI/LO execute unit (mult/div/mfhi/mflo/mthi/mtlo).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_muldiv
   import exec_muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             Start,
   input  logic [5:0]       Function_opcode,
   input  logic [WIDTH-1:0] Read_data_1,
   input  logic [WIDTH-1:0] Read_data_2,
   output logic             Stall,
   output logic             Done,
   output logic             Div_zero,
   output logic [WIDTH-1:0] MD_Result,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_is_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;
   logic [WIDTH-1:0] r_dividend;

   logic             w_idle;
   logic             w_hilo_op;
   logic             w_accept;
   logic             w_is_div;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic             w_dz;
   logic             w_step_done;
   logic [WIDTH-1:0] w_raw_hi;
   logic [WIDTH-1:0] w_raw_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;

   // funct[0] clear selects the signed variant; the core only ever sees magnitudes.
   always_comb begin
      w_idle    = (r_state == c_state_idle);
      w_hilo_op = Start && is_hilo(Function_opcode);
      w_accept  = w_idle && Start && is_muldiv(Function_opcode);
      w_is_div  = Function_opcode[1];
      w_a_neg   = !Function_opcode[0] && Read_data_1[WIDTH-1];
      w_b_neg   = !Function_opcode[0] && Read_data_2[WIDTH-1];
      w_abs_a   = w_a_neg ? -Read_data_1 : Read_data_1;
      w_abs_b   = w_b_neg ? -Read_data_2 : Read_data_2;
      w_dz      = w_is_div && (Read_data_2 == '0);
      w_prod    = r_neg_q ? -{w_raw_hi, w_raw_lo} : {w_raw_hi, w_raw_lo};
      w_quot    = r_neg_q ? -w_raw_lo : w_raw_lo;
      w_rem     = r_neg_r ? -w_raw_hi : w_raw_hi;
   end

   exec_muldiv_iter_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clock     (clock),
      .reset     (reset),
      .load      (w_accept && !w_dz),
      .is_div    (w_is_div),
      .op_a      (w_abs_a),
      .op_b      (w_abs_b),
      .step_done (w_step_done),
      .raw_hi    (w_raw_hi),
      .raw_lo    (w_raw_lo)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= c_state_idle;
         r_hi       <= '0;
         r_lo       <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         r_dividend <= '0;
      end else begin
         case (r_state)
            c_state_idle: begin
               if (w_accept) begin
                  r_is_div   <= w_is_div;
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_dz       <= w_dz;
                  r_dividend <= Read_data_1;
                  r_state    <= w_dz ? c_state_fix : c_state_calc;
               end else if (Start && Function_opcode == c_funct_mthi) begin
                  r_hi <= Read_data_1;
               end else if (Start && Function_opcode == c_funct_mtlo) begin
                  r_lo <= Read_data_1;
               end
            end
            c_state_calc: begin
               if (w_step_done) begin
                  r_state <= c_state_fix;
               end
            end
            c_state_fix: begin
               if (r_dz) begin
                  r_hi <= r_dividend;
                  r_lo <= '1;
               end else if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  {r_hi, r_lo} <= w_prod;
               end
               r_state <= c_state_idle;
            end
            default: r_state <= c_state_idle;
         endcase
      end
   end

   // A HI/LO instruction arriving during FIX is held so mfhi/mflo see the new values.
   always_comb begin
      Stall     = (r_state == c_state_calc) || w_accept || (!w_idle && w_hilo_op);
      Done      = (r_state == c_state_fix);
      Div_zero  = Done && r_dz;
      MD_Result = '0;
      if (w_idle && Start && Function_opcode == c_funct_mfhi) begin
         MD_Result = r_hi;
      end else if (w_idle && Start && Function_opcode == c_funct_mflo) begin
         MD_Result = r_lo;
      end
   end

   assign Hi = r_hi;
   assign Lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_exec_muldiv.sv
// ============================================================================
// Module : tb_exec_muldiv
// Brief  : Scoreboard bench for exec_muldiv with directed HI/LO vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exec_muldiv;

   localparam int WIDTH = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic             Start;
   logic [5:0]       Function_opcode;
   logic [WIDTH-1:0] Read_data_1;
   logic [WIDTH-1:0] Read_data_2;
   logic             Stall;
   logic             Done;
   logic             Div_zero;
   logic [WIDTH-1:0] MD_Result;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   typedef struct packed {
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      logic             dz;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   exec_muldiv #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clock           (clock),
      .reset           (reset),
      .Start           (Start),
      .Function_opcode (Function_opcode),
      .Read_data_1     (Read_data_1),
      .Read_data_2     (Read_data_2),
      .Stall           (Stall),
      .Done            (Done),
      .Div_zero        (Div_zero),
      .MD_Result       (MD_Result),
      .Hi              (Hi),
      .Lo              (Lo)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic drive(input logic s, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(posedge clock);
      #1;
      Start           = s;
      Function_opcode = f;
      Read_data_1     = a;
      Read_data_2     = b;
   endtask

   // Issue one mult/div, queue its result, then track stall and latency until Done.
   task automatic issue_md(input string name, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                           input logic edz);
      int   cyc;
      int   exp_lat;
      logic stall_ok;
      drive(1'b1, f, a, b);
      exp_q.push_back('{hi: eh, lo: el, dz: edz});
      name_q.push_back(name);
      @(negedge clock);
      check({name, "_stall_c0"}, 64'(Stall), 64'd1);
      drive(1'b0, 6'b100000, ~a, 32'd0);
      stall_ok = 1'b1;
      cyc      = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clock);
         cyc = i;
         if (Done) break;
         if (!Stall) stall_ok = 1'b0;
      end
      exp_lat = edz ? 1 : WIDTH + 1;
      check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
      check({name, "_stall_held"}, 64'(stall_ok), 64'd1);
      check({name, "_stall_low_at_done"}, 64'(Stall), 64'd0);
   endtask

   // Monitor: every Done pops one expectation; HI/LO are compared after the write edge.
   initial begin
      exp_t  e;
      string nm;
      logic  dz;
      forever begin
         @(negedge clock);
         if (!reset && Div_zero && !Done) begin
            check("div_zero_outside_done", 64'(Div_zero), 64'(Done));
         end
         if (!reset && Done) begin
            dz = Div_zero;
            if (exp_q.size() == 0) begin
               check("done_without_op", 64'(exp_q.size()), 64'd1);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               @(posedge clock);
               #1;
               check({nm, "_hi"}, 64'(Hi), 64'(e.hi));
               check({nm, "_lo"}, 64'(Lo), 64'(e.lo));
               check({nm, "_div_zero"}, 64'(dz), 64'(e.dz));
            end
         end
      end
   end

   initial begin
      int cyc;
      reset           = 1'b1;
      Start           = 1'b0;
      Function_opcode = 6'd0;
      Read_data_1     = '0;
      Read_data_2     = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_hi", 64'(Hi), 64'd0);
      check("reset_lo", 64'(Lo), 64'd0);
      check("reset_stall", 64'(Stall), 64'd0);
      check("reset_done", 64'(Done), 64'd0);
      check("reset_div_zero", 64'(Div_zero), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      issue_md("mult_neg2x3",  6'b011000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      issue_md("multu_max",    6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      issue_md("mult_min_min", 6'b011000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      issue_md("multu_2p16",   6'b011001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);
      issue_md("div_m7_2",     6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      issue_md("div_7_m2",     6'b011010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      issue_md("divu_7_2",     6'b011011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
      issue_md("div_min_m1",   6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      issue_md("divu_5_0",     6'b011011, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
      issue_md("div_m7_0",     6'b011010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

      // Move-to / move-from in IDLE
      drive(1'b1, 6'b010001, 32'h00001234, 32'd0);
      @(negedge clock);
      check("mthi_stall", 64'(Stall), 64'd0);
      drive(1'b1, 6'b010011, 32'h00005678, 32'd0);
      @(negedge clock);
      check("mthi_hi", 64'(Hi), 64'h1234);
      check("mtlo_stall", 64'(Stall), 64'd0);
      drive(1'b1, 6'b010000, 32'd0, 32'd0);
      @(negedge clock);
      check("mtlo_lo", 64'(Lo), 64'h5678);
      check("mfhi_result", 64'(MD_Result), 64'h1234);
      check("mfhi_stall", 64'(Stall), 64'd0);
      drive(1'b1, 6'b010010, 32'd0, 32'd0);
      @(negedge clock);
      check("mflo_result", 64'(MD_Result), 64'h5678);
      drive(1'b1, 6'b100000, 32'hDEAD, 32'hBEEF);
      @(negedge clock);
      check("other_funct_result", 64'(MD_Result), 64'd0);
      check("other_funct_stall", 64'(Stall), 64'd0);
      drive(1'b0, 6'b100000, 32'd0, 32'd0);
      @(negedge clock);
      check("other_funct_hi", 64'(Hi), 64'h1234);
      check("other_funct_lo", 64'(Lo), 64'h5678);

      // mflo held behind an in-flight divu; released the cycle after FIX
      drive(1'b1, 6'b011011, 32'd100, 32'd7);
      exp_q.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
      name_q.push_back("divu_100_7");
      drive(1'b1, 6'b010010, 32'hFFFF0000, 32'h0000FFFF);
      cyc = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clock);
         cyc = i;
         if (Done) check("hazard_stall_in_fix", 64'(Stall), 64'd1);
         if (!Stall) break;
      end
      check("hazard_release_cycle", 64'(cyc), 64'(WIDTH + 2));
      check("hazard_mflo_result", 64'(MD_Result), 64'd14);
      drive(1'b0, 6'b100000, 32'd0, 32'd0);

      // Reset in the middle of a divide aborts it
      drive(1'b1, 6'b010001, 32'h00001234, 32'd0);
      drive(1'b1, 6'b011010, 32'd100, 32'd3);
      @(negedge clock);
      check("abort_mthi_hi", 64'(Hi), 64'h1234);
      drive(1'b0, 6'b100000, 32'd0, 32'd0);
      repeat (5) @(negedge clock);
      check("abort_stall_mid_div", 64'(Stall), 64'd1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("abort_hi", 64'(Hi), 64'd0);
      check("abort_lo", 64'(Lo), 64'd0);
      check("abort_stall", 64'(Stall), 64'd0);
      check("abort_done", 64'(Done), 64'd0);
      drive(1'b1, 6'b010011, 32'h0000ABCD, 32'd0);
      @(negedge clock);
      check("abort_mtlo_stall", 64'(Stall), 64'd0);
      drive(1'b0, 6'b100000, 32'd0, 32'd0);
      @(negedge clock);
      check("abort_mtlo_lo", 64'(Lo), 64'hABCD);
      repeat (40) @(negedge clock);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
